// File: rtl/nibble_serializer.sv
// nibble_serializer: parallel-to-serial converter, MSB first, with a frame
// strobe and an end-of-word done pulse. Optional even-parity bit appended
// after the data bits when NIBBLE_SERIALIZER_PARITY_EN is defined.
module nibble_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             frame,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd3
  } state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_s_out;
  logic             r_frame;
  logic             r_done;

  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_rot;

  // Next counter value and the holding register rotated by one bit.
  // Rotating (rather than shifting) keeps every latched bit in the
  // register, so the XOR over it still equals the word's parity.
  always_comb begin
    w_cnt_nxt  = r_cnt + 1'b1;
    w_hold_rot = {r_hold[WIDTH-2:0], r_hold[WIDTH-1]};
  end

  // Ready only while idle; combinational by design.
  assign in_ready = (r_state == IDLE);

  assign s_out = r_s_out;
  assign frame = r_frame;
  assign done  = r_done;

  // Serializer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_s_out <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (in_valid) begin
            r_hold  <= in_data;
            r_cnt   <= '0;
            r_s_out <= in_data[WIDTH-1];
            r_frame <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_cnt == LAST_BIT) begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            r_s_out <= ^r_hold;
            r_frame <= 1'b1;
            r_state <= PARITY;
`else
            r_s_out <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b1;
            r_state <= GAP;
`endif
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_s_out <= r_hold[WIDTH-2];
            r_hold  <= w_hold_rot;
          end
        end

`ifdef NIBBLE_SERIALIZER_PARITY_EN
        PARITY: begin
          r_s_out <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b1;
          r_state <= GAP;
        end
`endif

        GAP: begin
          r_s_out <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_s_out <= 1'b0;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Scoreboard bench for nibble_serializer: a reference model pushes the
// expected serial frame of every accepted word; a monitor pops and compares.
module tb_nibble_serializer;

  localparam int W = 4;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = W + PAR;
  localparam int FRAME_CYC  = W + 2 + PAR;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         s_out;
  logic         frame;
  logic         done;

  nibble_serializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_out    (s_out),
    .frame    (frame),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  // Reference model: a word is taken whenever the block is free and valid
  // is high; the block is then busy for one full frame period.
  bit exp_bits[$];
  int exp_words[$];
  int busy         = 0;
  int acc_cnt      = 0;
  int cyc          = 0;
  int last_acc_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      exp_bits.delete();
      exp_words.delete();
    end else begin
      cyc++;
      if (busy == 0) begin
        if (in_valid) begin
          for (int i = W - 1; i >= 0; i--) exp_bits.push_back(in_data[i]);
          if (PAR == 1) exp_bits.push_back(^in_data);
          exp_words.push_back(FRAME_BITS);
          busy = FRAME_CYC - 1;
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      end else begin
        busy--;
      end
    end
  end

  // Monitor: compares each framed bit, the idle level, ready and done timing.
  int nbits      = 0;
  bit prev_frame = 0;
  bit prev_done  = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbits      = 0;
      prev_frame = 0;
      prev_done  = 0;
    end else begin
      chk("in_ready", int'(in_ready), int'(busy == 0));
      if (frame) begin
        if (exp_bits.size() == 0) fail("unexpected_frame_bit");
        else chk("s_out", int'(s_out), int'(exp_bits.pop_front()));
        nbits++;
      end else begin
        chk("s_out_unframed", int'(s_out), 0);
      end
      if (done) begin
        chk("done_follows_last_bit", int'(prev_frame), 1);
        chk("done_single_cycle", int'(prev_done), 0);
        if (exp_words.size() == 0) fail("unexpected_done");
        else chk("frame_length", nbits, exp_words.pop_front());
        nbits = 0;
      end
      prev_frame = frame;
      prev_done  = done;
    end
  end

  task automatic wait_accept(input string name);
    int start;
    bit got;
    start = acc_cnt;
    got   = 0;
    for (int i = 0; i < 4 * FRAME_CYC; i++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        got = 1;
        break;
      end
    end
    if (!got) fail({name, "_accept_timeout"});
  endtask

  task automatic send(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_accept("send");
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_out"},    int'(s_out),    0);
    chk({tag, "_frame"},    int'(frame),    0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset asserted between clock edges must act immediately.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single words, including an even- and an odd-parity pattern.
    send(4'b1011);
    repeat (FRAME_CYC) @(negedge clk);
    send(4'b1001);
    repeat (FRAME_CYC) @(negedge clk);

    // Back-to-back with valid held high.
    in_data  = 4'hA;
    in_valid = 1'b1;
    wait_accept("b2b_first");
    a1      = last_acc_cyc;
    in_data = 4'h5;
    wait_accept("b2b_second");
    chk("b2b_spacing", last_acc_cyc - a1, FRAME_CYC);
    in_valid = 1'b0;
    repeat (FRAME_CYC) @(negedge clk);

    // Input changes while busy must not disturb the word in flight.
    in_data  = 4'h3;
    in_valid = 1'b1;
    wait_accept("busy_first");
    a1      = last_acc_cyc;
    in_data = 4'hF;
    wait_accept("busy_second");
    chk("busy_spacing", last_acc_cyc - a1, FRAME_CYC);
    in_valid = 1'b0;
    repeat (FRAME_CYC) @(negedge clk);

    // Mid-word reset after the second bit; no acceptance during reset.
    send(4'hC);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    in_data  = 4'hF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(4'h9);
    repeat (FRAME_CYC) @(negedge clk);

    // Randomized traffic with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom_range(0, (1 << W) - 1)));
    end

    repeat (FRAME_CYC + 2) @(negedge clk);
    chk("drain_bits",  exp_bits.size(),  0);
    chk("drain_words", exp_words.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port s_out, output, 1 bit: serial bit stream, MSB first, driving the downstream 4-bit left-shift register's serial input s.
REQ-008 The block SHALL have port frame, output, 1 bit: high while s_out carries a data or parity bit.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a word.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, PARITY (present only with the macro) and GAP.
REQ-011 in_ready SHALL be combinational and equal to 1 exactly when state is IDLE.
REQ-012 A word SHALL be accepted at a rising edge where in_valid=1 and in_ready=1; in_data is latched into a holding register and the state goes to SHIFT.
REQ-013 in_valid and in_data SHALL be ignored in every state other than IDLE.
REQ-014 On the acceptance edge N, s_out SHALL become in_data[WIDTH-1] and frame SHALL become 1.
REQ-015 After edge N+k (1 <= k <= WIDTH-1), s_out SHALL equal the latched bit [WIDTH-1-k].
REQ-016 A bit counter of ceil(log2(WIDTH)) bits SHALL count data bits; it SHALL never wrap within a word.
REQ-017 After edge N+WIDTH, the state SHALL go to PARITY if compiled in, otherwise to GAP.
REQ-018 In GAP, s_out and frame SHALL be 0, done SHALL be 1 for that single cycle, and the next edge SHALL return the state to IDLE.
REQ-019 done and frame SHALL be 0 in all other states and cycles.
REQ-020 Throughput SHALL be one word per WIDTH+2 cycles without parity and WIDTH+3 cycles with parity, when in_valid is held high.
REQ-021 All outputs except in_ready SHALL be registered.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, without waiting for clk, force state=IDLE, s_out=0, frame=0, done=0, and clear the counter and holding register.
REQ-023 A reset mid-word SHALL discard the word with no done pulse; after release, the first rising edge with in_valid=1 SHALL accept a new word.
REQ-024 in_ready SHALL read 1 during reset, but no acceptance SHALL occur while rst_n=0.

Configuration
REQ-025 With macro NIBBLE_SERIALIZER_PARITY_EN defined, the PARITY state SHALL exist for one cycle after the last data bit, with s_out equal to the XOR of all latched bits (even parity) and frame=1.
REQ-026 Without NIBBLE_SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent and SHIFT SHALL go directly to GAP.

Verification
REQ-027 The bench SHALL cover reset: assert rst_n=0 between clock edges -> s_out=0, frame=0, done=0 and in_ready=1 immediately.
REQ-028 The bench SHALL cover a single word (no parity, WIDTH=4): in_data=4'b1011 with in_valid for one edge -> s_out=1,0,1,1 on the 4 following cycles with frame=1, then one GAP cycle with done=1, then in_ready=1.
REQ-029 The bench SHALL cover back-to-back traffic: in_valid held high with words 4'hA and 4'h5 -> accepts 6 cycles apart and s_out=1,0,1,0,(gap),(idle),0,1,0,1.
REQ-030 The bench SHALL cover busy input: change in_data to 4'hF during SHIFT of 4'h3 -> stream stays 0,0,1,1 and 4'hF is not accepted until in_ready=1.
REQ-031 The bench SHALL cover mid-word reset: pulse rst_n low after the second bit of 4'hC -> outputs 0 at once, no done pulse, and the next word 4'h9 serializes as 1,0,0,1.
REQ-032 The bench SHALL cover parity with NIBBLE_SERIALIZER_PARITY_EN: 4'b1011 -> s_out=1,0,1,1,1 with frame high for 5 cycles, then done; 4'b1001 gives a parity bit of 0.
